// File: rtl/fir_sample_feeder.sv
// Input stage for the 3-tap FIR: buffers samples in a FIFO and issues one at a time, waiting for done.
// Define FEEDER_TIMEOUT_EN to abandon a sample after TIMEOUT cycles in WAIT.
module fir_sample_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             datain,
    output logic                   datavalid,
    input  logic                   done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("fir_sample_feeder: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    datain_q, datain_d;
    logic          datavalid_q, datavalid_d;
    logic          timeout_err_q, timeout_err_d;
    logic          push;
    logic          issue;
    logic          expire;

`ifdef FEEDER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter idles at zero outside WAIT, so it is already cleared on entry.
    always_comb begin
        tmo_cnt_d = (state_q == S_WAIT) ? tmo_cnt_q + CW'(1) : '0;
        expire    = (state_q == S_WAIT) && !done && (tmo_cnt_q == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            datain_q      <= '0;
            datavalid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            datain_q      <= datain_d;
            datavalid_q   <= datavalid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // FIFO storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (level_q != '0) state_d = S_WAIT;
            S_WAIT:  if (done || expire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (level_q != LW'(DEPTH));
        push          = in_valid && in_ready;
        issue         = (state_q == S_IDLE) && (level_q != '0);
        mem_d         = mem_q;
        if (push) mem_d[wr_ptr_q] = in_data;
        wr_ptr_d      = push  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = issue ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d       = level_q + LW'(push) - LW'(issue);
        datain_d      = issue ? mem_q[rd_ptr_q] : datain_q;
        datavalid_d   = issue;
        timeout_err_d = expire;
    end

    assign datain      = datain_q;
    assign datavalid   = datavalid_q;
    assign busy        = (state_q == S_WAIT);
    assign level       = level_q;
    assign timeout_err = timeout_err_q;

endmodule
